// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC types, default widths/frequency and divisor clamp
package rtc_pkg;

    localparam int RTC_CNT_W     = 24;
    localparam int RTC_TRIM_W    = 8;
    localparam int RTC_BASE_FREQ = 10_000_000;

    typedef logic [RTC_CNT_W-1:0]         cnt_t;
    typedef logic signed [RTC_TRIM_W-1:0] trim_t;

    // Limits a signed divisor candidate to the range a w-bit counter can use: [1, 2^w-1].
    function automatic logic [63:0] clamp_div(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = $signed((64'd1 << w) - 64'd1);
        if (v < 64'sd1) begin
            return 64'd1;
        end else if (v > hi) begin
            return 64'(hi);
        end else begin
            return 64'(v);
        end
    endfunction

endpackage

// File: rtl/rtc_edge_sync.sv
// rtl/rtc_edge_sync.sv - 2-flop synchroniser plus rising-edge pulse for asynchronous RTC inputs
module rtc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/rtc_prescaler.sv
// rtl/rtc_prescaler.sv - programmable reference-edge divider with tick/square outputs; RTC_PRESCALER_TRIM_EN enables ppm trim
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int BASE_FREQ   = RTC_BASE_FREQ,
    parameter int CNT_W       = RTC_CNT_W,
    parameter int TRIM_W      = RTC_TRIM_W,
    parameter int TRIM_PERIOD = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              en,
    input  logic              div_valid,
    input  logic [CNT_W-1:0]  div_value,
    output logic              div_ready,
    input  logic [TRIM_W-1:0] trim_val,
    output logic              tick,
    output logic              sq,
    output logic [CNT_W-1:0]  sub_count
);

    localparam logic [CNT_W-1:0] BASE_DIV = CNT_W'(BASE_FREQ);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic trig_rise;

    rtc_edge_sync u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (trig),
        .rise (trig_rise)
    );

    logic [CNT_W-1:0] count_q,    count_d;
    logic [CNT_W-1:0] cur_div_q,  cur_div_d;
    logic [CNT_W-1:0] base_div_q, base_div_d;
    logic [CNT_W-1:0] pending_q,  pending_d;
    logic             pend_full_q, pend_full_d;
    logic             div_ready_q, div_ready_d;
    logic             tick_q,     tick_d;
    logic             sq_q,       sq_d;

    logic             count_en;
    logic             wrap;
    logic             xfer;
    logic [CNT_W-1:0] next_base;
    logic [CNT_W-1:0] next_div;

    assign count_en  = trig_rise & en;
    assign wrap      = count_en & (count_q == cur_div_q - ONE);
    assign xfer      = div_valid & div_ready_q;
    // A load captured before this wrap becomes the base for the period that starts now.
    assign next_base = pend_full_q ? pending_q : base_div_q;

`ifdef RTC_PRESCALER_TRIM_EN
    localparam int SEC_W = (TRIM_PERIOD > 1) ? $clog2(TRIM_PERIOD) : 1;
    localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(TRIM_PERIOD - 1);

    logic [SEC_W-1:0]        sec_cnt_q, sec_cnt_d;
    logic signed [CNT_W+1:0] trim_sum;

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        if (wrap) begin
            sec_cnt_d = (sec_cnt_q == LAST_SEC) ? '0 : sec_cnt_q + SEC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
        end
    end

    // Two guard bits keep base plus a negative trim from wrapping before the clamp sees it.
    assign trim_sum = $signed({2'b00, next_base}) + (CNT_W+2)'($signed(trim_val));
    assign next_div = (sec_cnt_d == LAST_SEC) ? CNT_W'(clamp_div(64'(trim_sum), CNT_W)) : next_base;
`else
    logic unused_trim;
    assign unused_trim = ^trim_val ^ (TRIM_PERIOD > 1);
    assign next_div    = next_base;
`endif

    always_comb begin
        count_d     = count_q;
        tick_d      = 1'b0;
        sq_d        = sq_q;
        base_div_d  = base_div_q;
        cur_div_d   = cur_div_q;
        pending_d   = pending_q;
        pend_full_d = pend_full_q;
        // Ready returns one cycle after the applying wrap, since pend_full_q is still set in that cycle.
        div_ready_d = ~pend_full_q & ~xfer;

        if (count_en) begin
            count_d = wrap ? '0 : count_q + ONE;
        end
        if (wrap) begin
            tick_d      = 1'b1;
            sq_d        = ~sq_q;
            base_div_d  = next_base;
            cur_div_d   = next_div;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pending_d   = (div_value == '0) ? ONE : div_value;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            cur_div_q   <= BASE_DIV;
            base_div_q  <= BASE_DIV;
            pending_q   <= '0;
            pend_full_q <= 1'b0;
            div_ready_q <= 1'b1;
            tick_q      <= 1'b0;
            sq_q        <= 1'b0;
        end else begin
            count_q     <= count_d;
            cur_div_q   <= cur_div_d;
            base_div_q  <= base_div_d;
            pending_q   <= pending_d;
            pend_full_q <= pend_full_d;
            div_ready_q <= div_ready_d;
            tick_q      <= tick_d;
            sq_q        <= sq_d;
        end
    end

    assign div_ready = div_ready_q;
    assign tick      = tick_q;
    assign sq        = sq_q;
    assign sub_count = count_q;

endmodule

// File: tb/tb_rtc_prescaler.sv
// tb/tb_rtc_prescaler.sv - randomized self-checking bench for rtc_prescaler against an edge-level period model
module tb_rtc_prescaler;

    localparam int TP = 4;
`ifdef RTC_PRESCALER_TRIM_EN
    localparam bit TRIM_ON = 1'b1;
`else
    localparam bit TRIM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trig = 1'b0;
    logic       en = 1'b1;
    logic       div_valid = 1'b0;
    logic [7:0] div_value = 8'd0;
    logic [7:0] trim_val = 8'd0;
    logic       div_ready;
    logic       tick;
    logic       sq;
    logic [7:0] sub_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: edges counted so far in the period, length of the period, divisor state, window slot.
    int m_cnt, m_period, m_base, m_pend, m_win;
    bit m_pend_full, m_sq;

    rtc_prescaler #(
        .BASE_FREQ   (10),
        .CNT_W       (8),
        .TRIM_W      (8),
        .TRIM_PERIOD (TP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .en        (en),
        .div_valid (div_valid),
        .div_value (div_value),
        .div_ready (div_ready),
        .trim_val  (trim_val),
        .tick      (tick),
        .sq        (sq),
        .sub_count (sub_count)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int clamp_i(int v);
        if (v < 1) return 1;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic model_reset();
        m_cnt       = 0;
        m_period    = 10;
        m_base      = 10;
        m_pend      = 0;
        m_pend_full = 1'b0;
        m_sq        = 1'b0;
        m_win       = 0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b1;
        trig      = 1'b0;
        div_valid = 1'b0;
        en        = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One trig pulse with random phases; optional load request held across the counting cycle.
    task automatic do_edge(input bit e, input bit ld, input int v, output bit got_tick);
        int hi, lo, ticks;
        bit exp_tick, applied, exp_ready, dr3, dr4;
        hi = int'($urandom_range(4, 2));
        lo = int'($urandom_range(4, 2));
        exp_ready = !m_pend_full;
        n_chk++;
        if (div_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL ready_idle: div_ready=%b expected %b", div_ready, exp_ready);
        end
        exp_tick = 1'b0;
        applied  = 1'b0;
        if (e) begin
            m_cnt++;
            if (m_cnt >= m_period) begin
                exp_tick = 1'b1;
                m_cnt    = 0;
                m_sq     = !m_sq;
                if (m_pend_full) begin
                    m_base      = m_pend;
                    m_pend_full = 1'b0;
                    applied     = 1'b1;
                end
                m_win = (m_win + 1) % TP;
                if (TRIM_ON && m_win == TP - 1) m_period = clamp_i(m_base + int'($signed(trim_val)));
                else m_period = m_base;
            end
        end
        if (ld && exp_ready) begin
            m_pend      = (v == 0) ? 1 : v;
            m_pend_full = 1'b1;
        end
        en    = e;
        trig  = 1'b1;
        ticks = 0;
        dr3   = 1'b0;
        dr4   = 1'b0;
        for (int c = 1; c <= hi + lo; c++) begin
            if (c == hi + 1) trig = 1'b0;
            if (c == 3 && ld) begin
                div_valid = 1'b1;
                div_value = 8'(v);
            end
            if (c == 4) div_valid = 1'b0;
            @(negedge clk);
            if (tick === 1'b1) ticks++;
            if (c == 3) dr3 = div_ready;
            if (c == 4) dr4 = div_ready;
        end
        en       = 1'b1;
        got_tick = (ticks != 0);
        n_chk++;
        if (ticks !== int'(exp_tick)) begin
            n_fail++;
            $display("FAIL tick_count: %0d tick cycles, expected %0d", ticks, exp_tick);
        end
        n_chk++;
        if (sub_count !== 8'(m_cnt)) begin
            n_fail++;
            $display("FAIL sub_count: got %0d expected %0d", sub_count, m_cnt);
        end
        n_chk++;
        if (sq !== m_sq) begin
            n_fail++;
            $display("FAIL sq: got %b expected %b", sq, m_sq);
        end
        if (applied) begin
            n_chk++;
            if (dr3 !== 1'b0 || dr4 !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_after_wrap: tick cycle %b next %b, expected 0 then 1", dr3, dr4);
            end
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        n_chk++;
        if (tick !== 1'b0 || sq !== 1'b0 || sub_count !== 8'd0 || div_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: tick=%b sq=%b sub=%0d rdy=%b expected 0 0 0 1",
                     tick, sq, sub_count, div_ready);
        end
    endtask

    task automatic test_basic();
        bit got;
        do_reset(2);
        for (int i = 1; i <= 25; i++) begin
            do_edge(1'b1, 1'b0, 0, got);
            n_chk++;
            if (got !== (i == 10 || i == 20)) begin
                n_fail++;
                $display("FAIL basic_tick edge %0d: got %b expected %b", i, got, (i == 10 || i == 20));
            end
            if (i == 10) begin
                n_chk++;
                if (sq !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_sq_first: got %b expected 1", sq);
                end
            end
        end
        n_chk++;
        if (sub_count !== 8'd5 || sq !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: sub=%0d sq=%b expected 5 0", sub_count, sq);
        end
    endtask

    task automatic test_load();
        bit got, exp;
        do_reset(2);
        for (int i = 1; i <= 22; i++) begin
            do_edge(1'b1, i == 3, 4, got);
            exp = (i == 10 || i == 14 || i == 18 || i == 22);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL load_tick edge %0d: got %b expected %b", i, got, exp);
            end
            if (i == 3) begin
                n_chk++;
                if (div_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_ready_low: got %b expected 0", div_ready);
                end
            end
        end
    endtask

    task automatic test_load_at_wrap();
        bit got, exp;
        do_reset(2);
        for (int i = 1; i <= 23; i++) begin
            do_edge(1'b1, i == 10, 0, got);
            exp = (i == 10 || i == 20 || i == 21 || i == 22 || i == 23);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL wrap_load_tick edge %0d: got %b expected %b", i, got, exp);
            end
        end
        n_chk++;
        if (sq !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_load_sq: got %b expected 1", sq);
        end
    endtask

    task automatic test_trim();
        bit got, exp;
        do_reset(2);
        trim_val = 8'd3;
        for (int i = 1; i <= 53; i++) begin
            do_edge(1'b1, 1'b0, 0, got);
            if (TRIM_ON) exp = (i == 10 || i == 20 || i == 30 || i == 43 || i == 53);
            else exp = (i % 10 == 0);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL trim_plus edge %0d: got %b expected %b", i, got, exp);
            end
        end
        do_reset(2);
        trim_val = 8'hEC;
        for (int i = 1; i <= 41; i++) begin
            do_edge(1'b1, 1'b0, 0, got);
            if (TRIM_ON) exp = (i == 10 || i == 20 || i == 30 || i == 31 || i == 41);
            else exp = (i % 10 == 0);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL trim_clamp edge %0d: got %b expected %b", i, got, exp);
            end
        end
        trim_val = 8'd0;
    endtask

    task automatic test_enable();
        bit got;
        do_reset(2);
        for (int i = 1; i <= 15; i++) begin
            do_edge(!(i >= 5 && i <= 9), 1'b0, 0, got);
            n_chk++;
            if (got !== (i == 15)) begin
                n_fail++;
                $display("FAIL enable_tick edge %0d: got %b expected %b", i, got, (i == 15));
            end
            if (i >= 5 && i <= 9) begin
                n_chk++;
                if (sub_count !== 8'd4) begin
                    n_fail++;
                    $display("FAIL enable_frozen edge %0d: sub=%0d expected 4", i, sub_count);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset(2);
        for (int i = 1; i <= 7; i++) do_edge(1'b1, i == 3, 4, got);
        n_chk++;
        if (sub_count !== 8'd7 || div_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset: sub=%0d rdy=%b expected 7 0", sub_count, div_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if (tick !== 1'b0 || sq !== 1'b0 || sub_count !== 8'd0 || div_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_state: tick=%b sq=%b sub=%0d rdy=%b expected 0 0 0 1",
                     tick, sq, sub_count, div_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 12; i++) begin
            do_edge(1'b1, 1'b0, 0, got);
            n_chk++;
            if (got !== (i == 10)) begin
                n_fail++;
                $display("FAIL post_reset_tick edge %0d: got %b expected %b", i, got, (i == 10));
            end
        end
    endtask

    task automatic test_random();
        bit got;
        do_reset(2);
        for (int i = 0; i < 200; i++) begin
            if (i % 20 == 0) trim_val = 8'(int'($urandom_range(40, 0)) - 20);
            do_edge($urandom_range(99, 0) < 85, $urandom_range(99, 0) < 12,
                    int'($urandom_range(12, 0)), got);
        end
        trim_val = 8'd0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_load();
        test_load_at_wrap();
        test_trim();
        test_enable();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rtc_prescaler.md
# rtc_prescaler

Runtime-programmable successor to the fixed oscillator divider. It counts rising edges of a free-running, asynchronous reference (`trig`) and emits a one-cycle `tick` and a 50 % square wave `sq` once per `divisor` edges. The divisor can be reloaded glitch-free over a valid/ready handshake, and an optional ppm trim stretches or shortens one period in every `TRIM_PERIOD`. It sits between the oscillator pin and the seconds/calendar counters of the RTC.

## Interface
- `BASE_FREQ`, 10_000_000: divisor after reset; must be ≥1 and < 2^CNT_W.
- `CNT_W`, 24: width of the edge counter and divisor.
- `TRIM_W`, 8: width of the signed trim value.
- `TRIM_PERIOD`, 60: ticks per trim window, ≥1.
- `clk` in 1: system clock, single domain.
- `rst` in 1: synchronous, active-high reset.
- `trig` in 1: raw reference oscillator, asynchronous to `clk`.
- `en` in 1: count enable.
- `div_valid` in 1: divisor load request.
- `div_value` in CNT_W: requested divisor.
- `div_ready` out 1: load slot free.
- `trim_val` in TRIM_W: signed edge adjustment for the trimmed period.
- `tick` out 1: one-cycle pulse at each wrap.
- `sq` out 1: toggles at each wrap.
- `sub_count` out CNT_W: current edge count within the period.

## Operation
- Input path: `trig` → 2-flop synchroniser → edge register; `edge = s2 & ~s3`.
- Counter: on `edge & en`:
  - if `count == cur_div-1`: `count←0`, `tick←1`, `sq←~sq`, `sec_cnt` advances (wraps at TRIM_PERIOD-1 → 0).
  - else `count←count+1`.
- `tick` is 0 in every other cycle. With `en` low, edges are discarded and `count`, `sq`, `sec_cnt` hold.
- Load handshake: transfer happens when `div_valid & div_ready`. The value goes into the `pending` register and `div_ready` drops the next cycle. At the next wrap, `base_div←pending` and `div_ready` rises the cycle after. A `div_value` of 0 is stored as 1. A transfer in the same cycle as a wrap applies at the following wrap.
- `cur_div` is computed at each wrap for the coming period:
  - it equals `base_div`, except when the coming period is the last of the window (`sec_cnt` becomes TRIM_PERIOD-1), where it equals `base_div + sign_extend(trim_val)`.
  - Arithmetic is CNT_W+2 signed; the result is clamped to [1, 2^CNT_W-1].
  - `trim_val` is sampled only at that wrap.
- Reset values:
  - `count` = 0, `sub_count` = 0, `sec_cnt` = 0, `tick` = 0, `sq` = 0.
  - `div_ready` = 1, `pending` cleared.
  - `base_div` = `cur_div` = BASE_FREQ; synchroniser flops = 0.
- Reset mid-period or with a load pending discards the pending load and restarts counting from 0.

## Timing
- `trig` rising edge to counted edge: 3 `clk` cycles (2 sync + 1 edge detect). `trig` high and low phases must each be ≥2 `clk` periods.
- On a wrap, `tick` and the `sq` toggle appear in the cycle after the edge is detected, and `count` reads 0 in that same cycle.
- `sub_count` is a registered copy of `count`: no extra latency.
- `div_ready` is low from the cycle after a transfer until the cycle after the applying wrap.

## Configuration
- `RTC_PRESCALER_TRIM_EN` defined: trim logic, `sec_cnt`, and clamp are present as described.
- Undefined:
  - `trim_val` is ignored and `sec_cnt` is removed.
  - `cur_div = base_div` always.
  - Ports stay present for pin compatibility.

## Structure
- Shared package `rtc_pkg`: `cnt_t` (CNT_W logic), `trim_t` (signed TRIM_W), the default BASE_FREQ constant, and a clamp function.
- Sub-module `rtc_edge_sync`: 2-flop synchroniser plus rising-edge pulse, reset to 0. It is reused by other RTC inputs.

## Test plan
Use BASE_FREQ=10, CNT_W=8, TRIM_PERIOD=4, `en`=1 unless stated.
- Reset then 25 `trig` rising edges → `tick` after edges 10 and 20 only; `sq` = 1 after the first tick, 0 after the second; `sub_count` = 5 at the end.
- Load `div_value`=4 at edge 3 → `div_ready` low; first period still 10 edges; next ticks every 4 edges; `div_ready` high one cycle after the first wrap.
- Load asserted in the wrap cycle → that period still uses the old divisor; the value applies one wrap later. `div_value`=0 → period of 1 edge, `tick` on every edge, `sq` toggling each edge.
- TRIM_EN, `trim_val`=+3 → periods 10, 10, 10, 13 repeating. `trim_val`=-20 → 4th period clamped to 1 edge. With TRIM_EN undefined, `trim_val`=+3 → all periods 10.
- `en` low for 5 edges mid-period → `sub_count` frozen and no `tick`; resume completes the period with 10 counted edges total.
- `rst` asserted at `sub_count`=7 with a load pending → all outputs reset values, `div_ready`=1, next tick after 10 edges.
